reg_dump_tx: RTL and testbench
==============================

# reg_dump_tx

Debug register-dump transmitter for the single-cycle MIPS core. It drives the core's register-readout select (`regNo`) and samples the returned 32-bit register value (`val`), walking a configurable range of registers. Each register is serialized as a 5-byte UART 8N1 frame on `tx`, so a host can capture the architectural register file after a program run. It sits beside the core top level and owns the other end of its `regNo`/`val` debug interface.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit; must be ≥ 2.
- `FIRST_REG`, default 0: first register index dumped; range 0..31.
- `LAST_REG`, default 31: last register index dumped; range 0..31, and `LAST_REG` ≥ `FIRST_REG`.

Ports:
- `clk`  input  1: single clock; all state updates on its rising edge.
- `startin`  input  1: reset, asynchronous and active-high.
- `dump_req`  input  1: start a dump; sampled only in IDLE.
- `regNo`  output  5: register select driven to the core's readout port.
- `val`  input  32: register value returned by the core; combinational with respect to `regNo`.
- `tx`  output  1: UART serial out; idle high; registered.
- `busy`  output  1: high from dump acceptance until the final stop bit completes.
- `done`  output  1: one-cycle pulse when the dump completes.

## Operation
- States:
  - IDLE
  - SETTLE: `regNo` stable for 1 cycle.
  - START / DATA / STOP: one byte.
  - NEXT: byte/register sequencing; zero-cycle decision folded into the STOP exit.
- Per-register frame is 5 bytes, in this order:
  - index byte `{3'b000, regNo}`;
  - `val[31:24]`, `val[23:16]`, `val[15:8]`, `val[7:0]`.
- Each byte is sent as start bit 0, then 8 data bits LSB first, then stop bit 1.
- `val` is captured into a 32-bit snapshot register at the end of SETTLE. Later changes on `val` do not affect the frame in flight.
- Transitions:
  - IDLE → SETTLE on `dump_req`=1. Sets `regNo`=`FIRST_REG` and `busy`=1.
  - SETTLE → START after 1 cycle; captures `val`.
  - START → DATA → STOP, each bit lasting exactly `CLKS_PER_BIT` cycles.
  - STOP exit, when byte count < 4: go to START for the next byte, with no idle gap.
  - STOP exit after byte 4, when `regNo` < `LAST_REG`: `regNo` += 1 and go to SETTLE. `tx` stays 1 during SETTLE.
  - STOP exit after byte 4, when `regNo` = `LAST_REG`: go to IDLE with `busy`=0 and `done`=1 for one cycle. `regNo` holds `LAST_REG`.
- Counters:
  - bit timer: counts 0..`CLKS_PER_BIT`-1;
  - bit index: 0..7;
  - byte index: 0..4;
  - `regNo` increment is 5-bit. Wrap-around is impossible because of the `LAST_REG` bound.
- `dump_req` while `busy`=1 is ignored and not queued.

## Timing
- Reset values, applied asynchronously while `startin`=1:
  - `tx`=1, `busy`=0, `done`=0, `regNo`=0;
  - state IDLE, all counters 0, snapshot 0.
- Latency: `dump_req` sampled high at edge k gives the following.
  - Cycle k+1: SETTLE, with `busy`=1 and `regNo` driven.
  - Edge k+2: `tx` falls, starting the start bit.
- Per-register duration: 1 + 50·`CLKS_PER_BIT` cycles.
- Full dump duration: (`LAST_REG`-`FIRST_REG`+1)·(1+50·`CLKS_PER_BIT`) cycles from the first SETTLE to the `done` pulse.
- `done` is high in the first IDLE cycle. A `dump_req` sampled in that same cycle is accepted and starts a new dump.
- Reset mid-operation: `tx` returns to 1 immediately, with no partial byte completion. The next `dump_req` restarts at `FIRST_REG`.

## Test plan
- Reset: assert `startin` with random prior activity → `tx`=1, `busy`=0, `done`=0, `regNo`=0 in the same cycle, held until release.
- Single register, with `CLKS_PER_BIT`=4, `FIRST_REG`=`LAST_REG`=5 and `val`=32'hDEADBEEF, pulse `dump_req`:
  - `regNo`=5;
  - `tx` carries bytes 0x05, 0xDE, 0xAD, 0xBE, 0xEF, each bit exactly 4 cycles;
  - `done` pulses 201 cycles after SETTLE entry.
- Full dump, with `CLKS_PER_BIT`=4, range 0..31, and a bench model returning `val`=32'h1000_0000 | `regNo`:
  - 160 bytes decoded, in index/value pairs 0..31;
  - `done` pulses 6432 cycles after the first SETTLE cycle.
- Snapshot: change `val` from 32'h12345678 to 32'hFFFFFFFF during byte 2 → the frame still transmits 0x12, 0x34, 0x56, 0x78.
- Request handling:
  - `dump_req` pulsed mid-dump → ignored: no restart and no extra frames.
  - `dump_req` held high in the `done` cycle → a new dump begins, with SETTLE on the next cycle.
- Reset mid-data-bit of byte 3 → `tx`=1 immediately and `busy`=0. A later `dump_req` restarts at the `FIRST_REG` index byte.

Source files
------------

// File: rtl/reg_dump_tx.sv
// Debug register-dump transmitter: walks regNo over [FIRST_REG, LAST_REG] and sends
// each register as a 5-byte UART 8N1 frame (index byte, then val MSB..LSB).
module reg_dump_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIRST_REG    = 0,
    parameter int unsigned LAST_REG     = 31
) (
    input  logic        clk,
    input  logic        startin,
    input  logic        dump_req,
    output logic [4:0]  regNo,
    input  logic [31:0] val,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_q, bit_d;
    logic [2:0]      byte_q, byte_d;
    logic [4:0]      regno_q, regno_d;
    logic [31:0]     snap_q, snap_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [7:0]      cur_byte_c;
    logic [2:0]      bit_nxt_c;
    logic            timer_end_c;

    // Byte currently on the wire, selected by byte index
    always_comb begin
        case (byte_q)
            3'd0:    cur_byte_c = {3'b000, regno_q};
            3'd1:    cur_byte_c = snap_q[31:24];
            3'd2:    cur_byte_c = snap_q[23:16];
            3'd3:    cur_byte_c = snap_q[15:8];
            default: cur_byte_c = snap_q[7:0];
        endcase
    end

    assign bit_nxt_c   = bit_q + 3'd1;
    assign timer_end_c = (timer_q == TIMER_MAX);

    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            regno_q <= '0;
            snap_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            regno_q <= regno_d;
            snap_q  <= snap_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and registered-output logic; the byte/register sequencing is the STOP exit
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        regno_d = regno_q;
        snap_d  = snap_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (dump_req) begin
                    state_d = S_SETTLE;
                    regno_d = 5'(FIRST_REG);
                    byte_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            S_SETTLE: begin
                snap_d  = val;
                state_d = S_START;
                timer_d = '0;
                bit_d   = '0;
                tx_d    = 1'b0;
            end
            S_START: begin
                if (timer_end_c) begin
                    timer_d = '0;
                    state_d = S_DATA;
                    tx_d    = cur_byte_c[0];
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DATA: begin
                if (timer_end_c) begin
                    timer_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nxt_c;
                        tx_d  = cur_byte_c[bit_nxt_c];
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_STOP: begin
                if (timer_end_c) begin
                    timer_d = '0;
                    if (byte_q < 3'd4) begin
                        byte_d  = byte_q + 3'd1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        byte_d = '0;
                        if (regno_q < 5'(LAST_REG)) begin
                            regno_d = regno_q + 5'd1;
                            state_d = S_SETTLE;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign regNo = regno_q;
    assign tx    = tx_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx: one single-register instance and one full-range instance,
// UART frames decoded from tx and compared against hand-computed bytes and cycle times.
module tb_reg_dump_tx;

    localparam int unsigned CPB  = 4;
    localparam int          BYTE = 10 * CPB;
    localparam int          REGT = 1 + 50 * CPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_one, rst_all, dump_one, dump_all;
    logic [31:0] val_one, val_all;
    logic [4:0]  regno_one, regno_all;
    logic        tx_one, tx_all, busy_one, busy_all, done_one, done_all;

    // Core model for the full-range instance
    always_comb val_all = 32'h1000_0000 | {27'd0, regno_all};

    reg_dump_tx #(.CLKS_PER_BIT(CPB), .FIRST_REG(5), .LAST_REG(5)) u_one (
        .clk(clk), .startin(rst_one), .dump_req(dump_one), .regNo(regno_one),
        .val(val_one), .tx(tx_one), .busy(busy_one), .done(done_one)
    );

    reg_dump_tx #(.CLKS_PER_BIT(CPB), .FIRST_REG(0), .LAST_REG(31)) u_all (
        .clk(clk), .startin(rst_all), .dump_req(dump_all), .regNo(regno_all),
        .val(val_all), .tx(tx_all), .busy(busy_all), .done(done_all)
    );

    logic       mon_sel = 1'b0;
    logic       tx_m, busy_m, done_m;
    logic [4:0] regno_m;
    assign tx_m    = mon_sel ? tx_all    : tx_one;
    assign busy_m  = mon_sel ? busy_all  : busy_one;
    assign done_m  = mon_sel ? done_all  : done_one;
    assign regno_m = mon_sel ? regno_all : regno_one;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int bad    = 0;
    int sc     = 0;
    int quiet  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decode one byte; every sample of every bit must agree, else bad is bumped
    task automatic recv_byte(output logic [7:0] b, output int t0);
        int n = 0;
        b = '0;
        @(negedge clk);
        while (tx_m !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) bad += 100;
        t0 = cyc;
        repeat (CPB - 1) begin
            @(negedge clk);
            if (tx_m !== 1'b0) bad++;
        end
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < int'(CPB); k++) begin
                @(negedge clk);
                if (k == 0) b[i] = tx_m;
                else if (tx_m !== b[i]) bad++;
            end
        end
        repeat (CPB) begin
            @(negedge clk);
            if (tx_m !== 1'b1) bad++;
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp, input int exp_t0);
        logic [7:0] b;
        int t0;
        recv_byte(b, t0);
        check(tag, 32'(b), 32'(exp));
        check({tag, "_t0"}, t0, exp_t0);
    endtask

    task automatic expect_frame(input string tag, input logic [4:0] r, input logic [31:0] v,
                                input int tb0);
        logic [7:0] e [5];
        e[0] = {3'b000, r};
        e[1] = v[31:24];
        e[2] = v[23:16];
        e[3] = v[15:8];
        e[4] = v[7:0];
        for (int j = 0; j < 5; j++)
            expect_byte($sformatf("%s_b%0d", tag, j), e[j], tb0 + j * BYTE);
    endtask

    // Called on a negedge; returns the cycle stamp of the SETTLE cycle
    task automatic pulse_req(output int s);
        if (mon_sel) dump_all = 1'b1;
        else         dump_one = 1'b1;
        @(negedge clk);
        dump_all = 1'b0;
        dump_one = 1'b0;
        s = cyc;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_tx"},    32'(tx_m),    32'd1);
        check({tag, "_busy"},  32'(busy_m),  32'd0);
        check({tag, "_done"},  32'(done_m),  32'd0);
        check({tag, "_regno"}, 32'(regno_m), 32'd0);
    endtask

    initial begin
        rst_one  = 1'b1;
        rst_all  = 1'b1;
        dump_one = 1'b0;
        dump_all = 1'b0;
        val_one  = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_one = 1'b0;
        rst_all = 1'b0;
        @(negedge clk);

        // Reset after random activity
        pulse_req(sc);
        repeat ($urandom_range(20, 150)) @(negedge clk);
        rst_one = 1'b1;
        #1;
        check_reset("rst_async");
        repeat (3) @(negedge clk);
        check_reset("rst_held");
        rst_one = 1'b0;
        @(negedge clk);

        // Single register, DEADBEEF
        pulse_req(sc);
        check("one_settle_busy",  32'(busy_m),  32'd1);
        check("one_settle_regno", 32'(regno_m), 32'd5);
        check("one_settle_tx",    32'(tx_m),    32'd1);
        bad = 0;
        expect_frame("one", 5'd5, 32'hDEAD_BEEF, sc + 1);
        check("one_bits", bad, 0);
        @(negedge clk);
        check("one_done",      32'(done_m),  32'd1);
        check("one_done_cyc",  cyc - sc,     REGT);
        check("one_busy_end",  32'(busy_m),  32'd0);
        check("one_regno_end", 32'(regno_m), 32'd5);
        @(negedge clk);
        check("one_done_pulse", 32'(done_m), 32'd0);

        // Snapshot holds while val changes; mid-dump request ignored
        val_one = 32'h1234_5678;
        pulse_req(sc);
        bad = 0;
        expect_byte("snap_b0", 8'h05, sc + 1);
        expect_byte("snap_b1", 8'h12, sc + 1 + BYTE);
        fork
            expect_byte("snap_b2", 8'h34, sc + 1 + 2 * BYTE);
            begin
                repeat (10) @(negedge clk);
                val_one = 32'hFFFF_FFFF;
            end
        join
        fork
            expect_byte("snap_b3", 8'h56, sc + 1 + 3 * BYTE);
            begin
                repeat (12) @(negedge clk);
                dump_one = 1'b1;
                @(negedge clk);
                dump_one = 1'b0;
            end
        join
        expect_byte("snap_b4", 8'h78, sc + 1 + 4 * BYTE);
        check("snap_bits", bad, 0);
        @(negedge clk);
        check("snap_done",     32'(done_m), 32'd1);
        check("snap_done_cyc", cyc - sc,    REGT);
        quiet = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) quiet++;
        end
        check("ign_quiet", quiet, 0);

        // Request held through the done cycle restarts immediately
        val_one = 32'h1234_5678;
        pulse_req(sc);
        bad = 0;
        expect_frame("held", 5'd5, 32'h1234_5678, sc + 1);
        dump_one = 1'b1;
        @(negedge clk);
        check("held_done",      32'(done_m), 32'd1);
        check("held_done_busy", 32'(busy_m), 32'd0);
        @(negedge clk);
        dump_one = 1'b0;
        sc = cyc;
        check("held_settle_busy",  32'(busy_m),  32'd1);
        check("held_settle_done",  32'(done_m),  32'd0);
        check("held_settle_regno", 32'(regno_m), 32'd5);

        // Reset in data bit 0 of byte 3 (0x56, bit0 = 0)
        expect_byte("rs_b0", 8'h05, sc + 1);
        expect_byte("rs_b1", 8'h12, sc + 1 + BYTE);
        expect_byte("rs_b2", 8'h34, sc + 1 + 2 * BYTE);
        repeat (6) @(negedge clk);
        check("rs_pre_tx", 32'(tx_m), 32'd0);
        rst_one = 1'b1;
        #1;
        check_reset("rs_mid");
        @(negedge clk);
        check("rs_mid_held_tx", 32'(tx_m), 32'd1);
        rst_one = 1'b0;
        @(negedge clk);
        pulse_req(sc);
        check("restart_regno", 32'(regno_m), 32'd5);
        expect_frame("restart", 5'd5, 32'h1234_5678, sc + 1);
        check("held_bits", bad, 0);
        @(negedge clk);
        check("restart_done",     32'(done_m), 32'd1);
        check("restart_done_cyc", cyc - sc,    REGT);

        // Full dump 0..31 on the second instance
        mon_sel = 1'b1;
        @(negedge clk);
        pulse_req(sc);
        check("all_settle_regno", 32'(regno_m), 32'd0);
        bad = 0;
        for (int r = 0; r < 32; r++)
            expect_frame($sformatf("all_r%0d", r), 5'(r), 32'h1000_0000 | 32'(r), sc + 1 + r * REGT);
        check("all_bits", bad, 0);
        @(negedge clk);
        check("all_done",      32'(done_m),  32'd1);
        check("all_done_cyc",  cyc - sc,     32 * REGT);
        check("all_regno_end", 32'(regno_m), 32'd31);
        check("all_busy_end",  32'(busy_m),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
